// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and default bus widths.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    STALL = 2'd2,
    ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter_starve_timer.sv
// Saturating count of CPU-busy cycles seen by a pending DMA request.
// o_expire fires on the busy cycle that brings the count up to STARVE_LIMIT.
module starve_timer #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  logic [7:0] r_cnt;
  logic [8:0] w_cnt_plus1;

  assign w_cnt_plus1 = {1'b0, r_cnt} + 9'd1;
  assign o_expire    = i_inc && (w_cnt_plus1 == 9'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter: CPU has fixed priority and a combinational passthrough,
// DMA is served in CPU-idle cycles or forced through by stalling the CPU after starvation.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_cpu_stall;
  logic              r_dma_ack;
  logic [DATA_W-1:0] r_dma_rdata;
  logic [ADDR_W-1:0] r_lat_addr;
  logic [DATA_W-1:0] r_lat_wdata;
  logic              r_lat_we;

  logic w_cpu_busy;
  logic w_dma_cycle;
  logic w_latch;
  logic w_expire;

  assign w_cpu_busy  = cpu_read | cpu_write;
  assign w_latch     = (r_state == IDLE) && dma_req;
  // The DMA owns the bus in a CPU-idle PEND cycle or unconditionally while the CPU is stalled.
  assign w_dma_cycle = ((r_state == PEND) && !w_cpu_busy) || (r_state == STALL);

  starve_timer #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_latch),
    .i_inc    ((r_state == PEND) && w_cpu_busy),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (dma_req) w_state_nxt = PEND;
      PEND: begin
        if (!w_cpu_busy)   w_state_nxt = ACK;
        else if (w_expire) w_state_nxt = STALL;
      end
      STALL:   w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cpu_stall <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_dma_rdata <= '0;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
      r_lat_we    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_stall <= (w_state_nxt == STALL);
      r_dma_ack   <= (w_state_nxt == ACK);
      if (w_latch) begin
        r_lat_addr  <= dma_addr;
        r_lat_wdata <= dma_wdata;
        r_lat_we    <= dma_we;
      end
      if (w_dma_cycle && !r_lat_we) begin
        r_dma_rdata <= mem_rdata;
      end
    end
  end

  // CPU writes during a stall never reach memory because the DMA owns the bus then.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (w_dma_cycle) begin
      mem_addr  = r_lat_addr;
      mem_wdata = r_lat_wdata;
      mem_we    = r_lat_we;
      mem_re    = ~r_lat_we;
    end else if (w_cpu_busy) begin
      mem_addr  = cpu_address;
      mem_wdata = cpu_dout;
      mem_we    = cpu_write;
      mem_re    = cpu_read & ~cpu_write;
    end
  end

  assign cpu_din   = mem_rdata;
  assign cpu_stall = r_cpu_stall;
  assign dma_ack   = r_dma_ack;
  assign dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized DMA/CPU traffic against a
// transaction-level model of when each DMA access lands and what memory should hold.
module tb_mem_arbiter;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_read = 1'b0, cpu_write = 1'b0;
  logic [7:0] cpu_address = '0, cpu_dout = '0;
  logic [7:0] cpu_din;
  logic       cpu_stall;
  logic       dma_req = 1'b0, dma_we = 1'b0;
  logic [7:0] dma_addr = '0, dma_wdata = '0;
  logic       dma_ack;
  logic [7:0] dma_rdata;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_we, mem_re;
  logic [7:0] mem_rdata;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = '0, ld_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(L)) dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic cpu_idle();
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic chk_bus(input string nm, input logic [7:0] a, input logic [7:0] d,
                         input logic we, input logic re);
    checks++;
    if ({mem_addr, mem_wdata, mem_we, mem_re} !== {a, d, we, re}) begin
      errors++;
      $display("FAIL %s: bus addr=%h wdata=%h we=%b re=%b, expected addr=%h wdata=%h we=%b re=%b",
               nm, mem_addr, mem_wdata, mem_we, mem_re, a, d, we, re);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({cpu_stall, dma_ack, dma_rdata} !== 10'd0) begin
      errors++;
      $display("FAIL reset_regs: stall=%b ack=%b rdata=%h, expected 0 0 00", cpu_stall, dma_ack, dma_rdata);
    end
    chk_bus("reset_bus", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_dma_read();
    load(8'h20, 8'h5A);
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20; dma_wdata = 8'hC3;
    #1 chk_bus("read_c0_idle", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1 chk_bus("read_c1_bus", 8'h20, 8'hC3, 1'b0, 1'b1);
    checks++;
    if (dma_ack !== 1'b0) begin
      errors++; $display("FAIL read_c1_ack: ack=%b expected 0", dma_ack);
    end
    @(negedge clk);
    dma_req = 1'b0;
    #1;
    checks++;
    if ({dma_ack, dma_rdata} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL read_c2_ack: ack=%b rdata=%h expected 1 5a", dma_ack, dma_rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({dma_ack, dma_rdata} !== {1'b0, 8'h5A}) begin
      errors++; $display("FAIL read_c3_hold: ack=%b rdata=%h expected 0 5a", dma_ack, dma_rdata);
    end
  endtask

  task automatic test_reset_mid_pend();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20;
      cpu_read = 1'b1; cpu_address = 8'h01;
    end
    #3 rst = 1'b0;
    cpu_idle();
    #1;
    checks++;
    if ({cpu_stall, dma_ack, dma_rdata} !== 10'd0) begin
      errors++;
      $display("FAIL midpend_regs: stall=%b ack=%b rdata=%h, expected 0 0 00", cpu_stall, dma_ack, dma_rdata);
    end
    chk_bus("midpend_bus", 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1; dma_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (dma_ack !== 1'b0) begin
        errors++; $display("FAIL midpend_noack: cycle %0d ack=%b expected 0", k, dma_ack);
      end
    end
  endtask

  task automatic test_conflict();
    int acks = 0;
    load(8'h10, 8'h00);
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h10; dma_wdata = 8'h33;
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_address = 8'h40; cpu_dout = 8'h11;
    #1 chk_bus("conf_c0_cpu", 8'h40, 8'h11, 1'b1, 1'b0);
    @(negedge clk);
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 8'h41;
    #1 chk_bus("conf_c1_cpu", 8'h41, 8'h11, 1'b0, 1'b1);
    @(negedge clk);
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_address = 8'h42; cpu_dout = 8'h22;
    #1 chk_bus("conf_c2_cpu", 8'h42, 8'h22, 1'b1, 1'b0);
    @(negedge clk);
    cpu_idle();
    #1 chk_bus("conf_c3_dma", 8'h10, 8'h33, 1'b1, 1'b0);
    for (int k = 4; k < 9; k++) begin
      @(negedge clk);
      dma_req = 1'b0;
      #1;
      if (dma_ack === 1'b1) acks++;
      checks++;
      if (cpu_stall !== 1'b0) begin
        errors++; $display("FAIL conf_nostall: cycle %0d stall=%b expected 0", k, cpu_stall);
      end
    end
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL conf_acks: got %0d acks expected 1", acks);
    end
    checks++;
    if ({mem[8'h10], mem[8'h40], mem[8'h42]} !== {8'h33, 8'h11, 8'h22}) begin
      errors++;
      $display("FAIL conf_mem: mem10=%h mem40=%h mem42=%h expected 33 11 22", mem[8'h10], mem[8'h40], mem[8'h42]);
    end
  endtask

  task automatic test_starvation();
    load(8'h50, 8'h00);
    load(8'h51, 8'h00);
    load(8'h30, 8'h00);
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h30; dma_wdata = 8'h77;
      cpu_read = 1'b0; cpu_write = 1'b1; cpu_address = 8'h50; cpu_dout = 8'(k);
      #1 chk_bus("starve_cpu", 8'h50, 8'(k), 1'b1, 1'b0);
      checks++;
      if (cpu_stall !== 1'b0) begin
        errors++; $display("FAIL starve_early: cycle %0d stall=%b expected 0", k, cpu_stall);
      end
    end
    @(negedge clk);
    cpu_address = 8'h51; cpu_dout = 8'hEE;
    #1 chk_bus("starve_dma", 8'h30, 8'h77, 1'b1, 1'b0);
    checks++;
    if ({cpu_stall, cpu_din} !== {1'b1, mem_rdata}) begin
      errors++; $display("FAIL starve_stall: stall=%b din=%h expected 1 %h", cpu_stall, cpu_din, mem_rdata);
    end
    @(negedge clk);
    cpu_idle(); dma_req = 1'b0;
    #1;
    checks++;
    if ({cpu_stall, dma_ack} !== 2'b01) begin
      errors++; $display("FAIL starve_ack: stall=%b ack=%b expected 0 1", cpu_stall, dma_ack);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({cpu_stall, dma_ack} !== 2'b00) begin
      errors++; $display("FAIL starve_after: stall=%b ack=%b expected 0 0", cpu_stall, dma_ack);
    end
    checks++;
    if ({mem[8'h30], mem[8'h50], mem[8'h51]} !== {8'h77, 8'(L), 8'h00}) begin
      errors++;
      $display("FAIL starve_mem: mem30=%h mem50=%h mem51=%h expected 77 %h 00", mem[8'h30], mem[8'h50], mem[8'h51], 8'(L));
    end
  endtask

  task automatic test_back_to_back();
    int ack_cyc [$];
    logic [7:0] rd [$];
    load(8'h20, 8'h5A);
    load(8'h10, 8'h33);
    cpu_idle();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dma_req = (k < 6); dma_we = 1'b0;
      dma_addr = (k < 3) ? 8'h20 : 8'h10;
      #1;
      if (dma_ack === 1'b1) begin
        ack_cyc.push_back(k);
        rd.push_back(dma_rdata);
      end
    end
    checks++;
    if (ack_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d acks expected 2", ack_cyc.size());
    end else begin
      checks++;
      if ((ack_cyc[1] - ack_cyc[0]) != 3 || ack_cyc[0] != 2) begin
        errors++; $display("FAIL b2b_spacing: acks at %0d,%0d expected 2,5", ack_cyc[0], ack_cyc[1]);
      end
      checks++;
      if ({rd[0], rd[1]} !== {8'h5A, 8'h33}) begin
        errors++; $display("FAIL b2b_data: got %h,%h expected 5a,33", rd[0], rd[1]);
      end
    end
  endtask

  task automatic test_rw_priority();
    load(8'h07, 8'h00);
    @(negedge clk);
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 8'h07; cpu_dout = 8'h99;
    #1 chk_bus("prio_bus", 8'h07, 8'h99, 1'b1, 1'b0);
    checks++;
    if (cpu_din !== mem_rdata) begin
      errors++; $display("FAIL prio_din: din=%h expected %h", cpu_din, mem_rdata);
    end
    @(negedge clk);
    cpu_read = 1'b1; cpu_write = 1'b0;
    #1;
    checks++;
    if ({mem[8'h07], cpu_din} !== {8'h99, 8'h99}) begin
      errors++; $display("FAIL prio_mem: mem07=%h din=%h expected 99 99", mem[8'h07], cpu_din);
    end
    @(negedge clk);
    cpu_idle();
  endtask

  task automatic test_random();
    logic [7:0] exp_rd = '0;
    bit         rd_valid = 1'b0;
    for (int i = 0; i < 16; i++) load(8'h80 + 8'(i), 8'($urandom));
    for (int n = 0; n < 60; n++) begin
      logic [7:0] da, dwd, ea, ed;
      logic       dwe, ewe, ere;
      bit         busy [8];
      int         a;
      da  = 8'h80 + 8'($urandom_range(0, 15));
      dwd = 8'($urandom);
      dwe = 1'($urandom);
      for (int k = 0; k < 8; k++) busy[k] = ($urandom_range(0, 9) < 7);
      a = L + 1;
      for (int j = L; j >= 1; j--) if (!busy[j]) a = j;
      for (int k = 0; k <= a + 1; k++) begin
        int op;
        @(negedge clk);
        dma_req = (k <= a); dma_we = dwe; dma_addr = da; dma_wdata = dwd;
        op = $urandom_range(0, 2);
        cpu_read    = busy[k] && (op != 1);
        cpu_write   = busy[k] && (op != 0);
        cpu_address = 8'h80 + 8'($urandom_range(0, 15));
        cpu_dout    = 8'($urandom);
        #1;
        {ea, ed, ewe, ere} = '0;
        if (k == a) begin
          {ea, ed, ewe, ere} = {da, dwd, dwe, ~dwe};
          if (dwe) ref_mem[da] = dwd;
          else begin exp_rd = ref_mem[da]; rd_valid = 1'b1; end
        end else if (busy[k]) begin
          {ea, ed, ewe, ere} = {cpu_address, cpu_dout, cpu_write, cpu_read & ~cpu_write};
          if (cpu_write) ref_mem[cpu_address] = cpu_dout;
        end
        chk_bus("rand_bus", ea, ed, ewe, ere);
        checks++;
        if ({cpu_stall, dma_ack} !== {(k == a) && (a == L + 1), k == a + 1}) begin
          errors++;
          $display("FAIL rand_ctrl: txn %0d cycle %0d stall=%b ack=%b expected %b %b", n, k,
                   cpu_stall, dma_ack, (k == a) && (a == L + 1), k == a + 1);
        end
        if (k == a + 1 && rd_valid) begin
          checks++;
          if (dma_rdata !== exp_rd) begin
            errors++; $display("FAIL rand_rdata: txn %0d rdata=%h expected %h", n, dma_rdata, exp_rd);
          end
        end
      end
    end
    @(negedge clk);
    cpu_idle(); dma_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[8'h80 + 8'(i)] !== ref_mem[8'h80 + 8'(i)]) begin
        errors++;
        $display("FAIL rand_mem: addr %h got %h expected %h", 8'h80 + 8'(i), mem[8'h80 + 8'(i)], ref_mem[8'h80 + 8'(i)]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dma_read();
    test_reset_mid_pend();
    test_conflict();
    test_starvation();
    test_back_to_back();
    test_rw_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port data memory between the CPU load/store port and a secondary DMA/debug requester, such as a UART program loader.
- CPU has fixed priority and a zero-latency passthrough.
- DMA uses a req/ack handshake and is served in CPU-idle cycles.
- A starvation timer raises cpu_stall, which the CPU consumes as a clock-enable, so a waiting DMA access is forced through.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
STARVE_LIMIT, 4, consecutive CPU-busy cycles a pending DMA request tolerates before stall (legal range 1..255)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
cpu_read  in  1  CPU read request
cpu_write  in  1  CPU write request
cpu_address  in  ADDR_W  CPU address
cpu_dout  in  DATA_W  CPU write data
cpu_din  out  DATA_W  read data to CPU (= mem_rdata)
cpu_stall  out  1  registered; CPU holds all state while high
dma_req  in  1  DMA request, level; held with addr/we/wdata until dma_ack
dma_we  in  1  1 = write, 0 = read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_ack  out  1  registered one-cycle completion pulse
dma_rdata  out  DATA_W  registered read data, valid when dma_ack=1 and held until next ack
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_re  out  1  memory read strobe
mem_rdata  in  DATA_W  asynchronous-read memory data

Behaviour:
- Reset (rst=0, async): state IDLE; cpu_stall, dma_ack and wait_cnt = 0; dma_rdata and latched DMA regs = 0. A DMA request in flight is dropped and no ack is issued.
- States: IDLE, PEND, STALL, ACK.
- IDLE: when dma_req=1, latch dma_addr/dma_we/dma_wdata, clear wait_cnt, go to PEND. No bus access happens in this cycle.
- PEND, CPU idle (cpu_read=cpu_write=0): the bus carries the latched DMA access this cycle. On the edge, capture mem_rdata into dma_rdata if it is a read (writes leave dma_rdata unchanged), then go to ACK.
- PEND, CPU busy: the CPU owns the bus. wait_cnt increments, saturating. When wait_cnt+1 == STARVE_LIMIT, go to STALL and set cpu_stall=1 on that edge.
- STALL: cpu_stall=1 and the bus carries the DMA access regardless of CPU strobes. CPU writes are suppressed; cpu_din is still driven. Capture as in PEND, go to ACK, clear cpu_stall.
- ACK: dma_ack=1 for exactly one cycle, then go to IDLE. dma_req still high in the following IDLE cycle is a new request. Minimum request-to-ack latency is 2 cycles.
- Bus mux (combinational):
  - DMA access cycle: mem_addr/mem_wdata come from the latched regs; mem_we = latched we; mem_re = ~latched we.
  - Otherwise the CPU drives: mem_addr = cpu_address, mem_wdata = cpu_dout, mem_we = cpu_write, mem_re = cpu_read & ~cpu_write.
  - No requester: all mem_* outputs = 0.
- cpu_read and cpu_write both high: the write wins and mem_re=0.
- STARVE_LIMIT=1: the first busy PEND cycle enters STALL.
- A CPU access is never delayed or dropped outside STALL cycles.
- dma_req falling before ack is a protocol violation; the latched access still completes and is acked.

Decomposition:
- mem_arb_pkg: state encoding localparams (IDLE=0, PEND=1, STALL=2, ACK=3) and default ADDR_W/DATA_W.
- One sub-module, starve_timer: a saturating counter with clear/inc inputs and an expire output at STARVE_LIMIT.
- The top module holds the FSM, latch registers and bus mux.

Test Plan:
1. Reset check: assert rst=0 mid-PEND with dma_req=1 -> all registered outputs 0, no dma_ack after release, mem_* = 0 with no requester.
2. DMA read, CPU idle: mem[0x20]=0x5A, dma_req at cycle 0 -> mem_addr=0x20 and mem_re=1 in cycle 1; dma_ack=1 with dma_rdata=0x5A in cycle 2 only.
3. Conflict: dma_req write 0x33 to 0x10 with CPU busy 2 cycles (STARVE_LIMIT=4) -> CPU accesses pass untouched, DMA write in the first idle cycle, mem[0x10]=0x33, single ack.
4. Starvation: CPU busy continuously, STARVE_LIMIT=4 -> cpu_stall=1 for exactly one cycle after 4 busy PEND cycles, DMA access in that cycle, CPU write during the stall is not committed.
5. Back-to-back: dma_req held high across an ack -> the second access starts from IDLE, acks are 3 cycles apart, both data values are correct.
6. CPU read/write priority: cpu_read=cpu_write=1 at 0x07 with 0x99 -> mem_we=1, mem_re=0, mem[0x07]=0x99, cpu_din=mem_rdata.
